// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and duty (tenths) of an asynchronous PWM input,
// with a sequential duty divider, overrun flagging and static-input (stuck) detection.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             en,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic [3:0]       duty_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             stuck_o,
  output logic             overrun_o
);
  localparam int AW = CNT_W + 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [CNT_W-1:0] MAX = '1;

  logic             s1_q, s2_q, s3_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] per_q, per_d, hs_q, hs_d;
  logic [3:0]       q_q, q_d;
  logic             run_q, run_d, fin_q, fin_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [3:0]       duty_q, duty_d;
  logic             valid_q, valid_d, stuck_q, stuck_d, ovr_q, ovr_d;
  logic             rise, fall, busy, capture, timeout;

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign busy    = run_q | fin_q;
  assign capture = rise && state_q == LOW;
  // A rise in the same cycle as saturation wins; once stuck, no repeat events.
  assign timeout = cnt_q == MAX && !rise && !stuck_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = !en ? '0 : rise ? CNT_W'(1) : cnt_q == MAX ? cnt_q : cnt_q + CNT_W'(1);
    hi_d     = hi_q;
    acc_d    = acc_q;
    per_d    = per_q;
    hs_d     = hs_q;
    q_d      = q_q;
    run_d    = run_q;
    fin_d    = 1'b0;
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    ovr_d    = ovr_q;
    if (!en) begin
      state_d = IDLE;
      hi_d    = '0;
      acc_d   = '0;
      per_d   = '0;
      hs_d    = '0;
      q_d     = '0;
      run_d   = 1'b0;
    end else if (timeout) begin
      state_d  = IDLE;
      run_d    = 1'b0;
      ovr_d    = ovr_q | busy;
      period_d = '0;
      high_d   = '0;
      duty_d   = s2_q ? 4'd10 : 4'd0;
      valid_d  = 1'b1;
      stuck_d  = 1'b1;
    end else begin
      if (rise) begin
        state_d = HIGH;
        stuck_d = 1'b0;
      end else if (fall && state_q == HIGH) begin
        state_d = LOW;
        hi_d    = cnt_q;
      end
      if (capture && busy) begin
        ovr_d = 1'b1;
      end else if (capture) begin
        acc_d = AW'(hi_q) * AW'(10);
        per_d = cnt_q;
        hs_d  = hi_q;
        q_d   = '0;
        run_d = 1'b1;
      end
      // Restoring divide by repeated subtraction: q+1 cycles, result registered next edge.
      if (run_q && acc_q < AW'(per_q)) begin
        run_d    = 1'b0;
        fin_d    = 1'b1;
        period_d = per_q;
        high_d   = hs_q;
        duty_d   = q_q;
        valid_d  = 1'b1;
      end else if (run_q) begin
        acc_d = acc_q - AW'(per_q);
        q_d   = q_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      acc_q    <= '0;
      per_q    <= '0;
      hs_q     <= '0;
      q_q      <= '0;
      run_q    <= 1'b0;
      fin_q    <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      s1_q     <= pwm_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      acc_q    <= acc_d;
      per_q    <= per_d;
      hs_q     <= hs_d;
      q_q      <= q_d;
      run_q    <= run_d;
      fin_q    <= fin_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      ovr_q    <= ovr_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign duty_o    = duty_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy;
  assign stuck_o   = stuck_q;
  assign overrun_o = ovr_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: event-level reference model compared every cycle, plus literal spot checks.
module tb_pwm_capture;
  localparam int W = 10;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0, rst = 1'b1, pwm_in = 1'b0, en = 1'b1;
  logic [W-1:0] period_o, high_o;
  logic [3:0] duty_o;
  logic valid_o, busy_o, stuck_o, overrun_o;

  pwm_capture #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .en(en),
    .period_o(period_o), .high_o(high_o), .duty_o(duty_o),
    .valid_o(valid_o), .busy_o(busy_o), .stuck_o(stuck_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: seen level is the input two samples back; age is cycles since the last rise.
  int cyc = 0, age = 0, hi_t = 0, phase = 0, pub = 0, c_per = 0, c_hi = 0, c_q = 0;
  bit h1, h2, h3, pend, stk, ovr, r, f, bz, lvl;
  int e_per = 0, e_hi = 0, e_duty = 0;
  bit e_val, e_busy;

  always @(posedge clk) begin
    cyc++;
    r = h2 & !h3;
    f = !h2 & h3;
    lvl = h2;
    e_val = 0;
    if (rst) begin
      {h1, h2, h3, pend, stk, ovr} = '0;
      age = 0; hi_t = 0; phase = 0;
      e_per = 0; e_hi = 0; e_duty = 0;
    end else begin
      h3 = h2; h2 = h1; h1 = pwm_in;
      if (!en) begin
        phase = 0; age = 0; hi_t = 0; pend = 0;
      end else begin
        bz = pend;
        if (pend && cyc == pub + 1) pend = 0;
        if (age == MAX && !r && !stk) begin
          if (bz) ovr = 1;
          pend = 0; stk = 1; phase = 0;
          e_per = 0; e_hi = 0; e_duty = lvl ? 10 : 0; e_val = 1;
        end else begin
          if (pend && cyc == pub) begin
            e_per = c_per; e_hi = c_hi; e_duty = c_q; e_val = 1;
          end
          if (f && phase == 1) begin
            hi_t = age; phase = 2;
          end else if (r) begin
            stk = 0;
            if (phase == 2 && bz) ovr = 1;
            else if (phase == 2) begin
              c_per = age; c_hi = hi_t; c_q = 10 * hi_t / age;
              pend = 1; pub = cyc + c_q + 1;
            end
            phase = 1;
          end
        end
        age = r ? 1 : (age < MAX ? age + 1 : MAX);
      end
    end
    e_busy = pend;
  end

  always @(negedge clk) if (cyc > 0) begin
    chk("period_o", int'(period_o), e_per);
    chk("high_o", int'(high_o), e_hi);
    chk("duty_o", int'(duty_o), e_duty);
    chk("valid_o", int'(valid_o), int'(e_val));
    chk("busy_o", int'(busy_o), int'(e_busy));
    chk("stuck_o", int'(stuck_o), int'(stk));
    chk("overrun_o", int'(overrun_o), int'(ovr));
  end

  int lv_per = -1, lv_hi = -1, lv_duty = -1, vcount = 0;
  always @(negedge clk) if (valid_o) begin
    lv_per = int'(period_o); lv_hi = int'(high_o); lv_duty = int'(duty_o); vcount++;
  end

  task automatic drive(bit v);
    pwm_in = v;
    @(posedge clk);
    #2;
  endtask

  task automatic run(int per, int hi, int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < per; j++) drive(j < hi);
  endtask

  task automatic zeros(string tag);
    chk({tag, "_period"}, int'(period_o), 0);
    chk({tag, "_high"}, int'(high_o), 0);
    chk({tag, "_duty"}, int'(duty_o), 0);
    chk({tag, "_valid"}, int'(valid_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_stuck"}, int'(stuck_o), 0);
    chk({tag, "_overrun"}, int'(overrun_o), 0);
  endtask

  int v0;
  initial begin
    @(posedge clk); #2;
    repeat (3) drive(0);
    zeros("reset");
    rst = 0;
    run(10, 5, 6);
    chk("d5_period", lv_per, 10);
    chk("d5_high", lv_hi, 5);
    chk("d5_duty", lv_duty, 5);
    chk("d5_overrun", int'(overrun_o), 0);
    for (int h = 0; h < 10; h++) begin
      run(10, h, 4);
      if (h > 0) chk("sweep_duty", lv_duty, h);
    end
    repeat (MAX + 10) drive(1);
    chk("hi_stuck", int'(stuck_o), 1);
    chk("hi_duty", lv_duty, 10);
    chk("hi_period", lv_per, 0);
    run(7, 3, 5);
    chk("p7_stuck", int'(stuck_o), 0);
    chk("p7_period", lv_per, 7);
    chk("p7_high", lv_hi, 3);
    chk("p7_duty", lv_duty, 4);
    rst = 1;
    repeat (3) drive(0);
    rst = 0;
    chk("pre_overrun", int'(overrun_o), 0);
    run(4, 2, 8);
    chk("p4_overrun", int'(overrun_o), 1);
    chk("p4_period", lv_per, 4);
    chk("p4_high", lv_hi, 2);
    chk("p4_duty", lv_duty, 5);
    run(10, 5, 4);
    repeat (MAX + 10) drive(0);
    chk("lo_stuck", int'(stuck_o), 1);
    chk("lo_duty", lv_duty, 0);
    chk("lo_period", lv_per, 0);
    repeat (5) drive(1);
    chk("lo_unstuck", int'(stuck_o), 0);
    repeat (5) drive(0);
    run(10, 5, 3);
    drive(1); drive(1);
    rst = 1;
    drive(1); drive(1);
    zeros("midrst");
    rst = 0;
    v0 = vcount;
    repeat (3) drive(1);
    repeat (5) drive(0);
    chk("midrst_novalid", vcount - v0, 0);
    run(10, 5, 4);
    chk("resume_period", lv_per, 10);
    chk("resume_duty", lv_duty, 5);
    for (int i = 0; i < 250; i++) begin
      int per;
      per = $urandom_range(2, 25);
      run(per, $urandom_range(0, per - 1), $urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) begin
        en = 0;
        repeat ($urandom_range(1, 4)) drive(pwm_in);
        en = 1;
      end
    end
    repeat (400) drive(1'($urandom_range(0, 1)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
